vga_tile_ctrl: RTL and testbench

Parametrised tile-mapped VGA controller, the display front end of the single-cycle ARM system. It generates VGA timing and fetches 8-bit tile colours from the data memory video port, four tiles per 32-bit word. It drives 4-bit RGB and the sync pins. Timing, tile size, grid size, sync polarity and memory read latency are all parameters. Beyond the fixed-size controller it adds a border colour for screen area outside the tile grid, and a vblank status and strobe so software can synchronise framebuffer updates.

---
 rtl/vga_pkg.sv | 9 +
 rtl/vga_timing.sv | 44 ++++
 rtl/vga_tile_ctrl.sv | 87 ++++++++
 tb/tb_vga_tile_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, pixel-byte fields and total helper
package vga_pkg;
  localparam int H_ACTIVE_D = 640, H_FP_D = 16, H_SYNC_D = 96, H_BP_D = 48;
  localparam int V_ACTIVE_D = 480, V_FP_D = 10, V_SYNC_D = 2, V_BP_D = 33;
  localparam int R_HI = 5, R_LO = 4, G_HI = 3, G_LO = 2, B_HI = 1, B_LO = 0;
  function automatic int vga_total(input int active, fp, sync, bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel/line counters with raw sync, active and vblank terms
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP = V_BP_D,
  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
)(
  input  logic          clk,
  input  logic          reset,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          hs,
  output logic          vs,
  output logic          active,
  output logic          vblank,
  output logic          vblank_start
);
  logic h_wrap;
  assign h_wrap = int'(hcnt) == H_TOTAL - 1;
  // hcnt wraps every line; vcnt advances on each hcnt wrap
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= h_wrap ? '0 : hcnt + HW'(1);
      if (h_wrap) vcnt <= int'(vcnt) == V_TOTAL - 1 ? '0 : vcnt + VW'(1);
    end
  assign hs = int'(hcnt) >= H_ACTIVE + H_FP && int'(hcnt) < H_ACTIVE + H_FP + H_SYNC;
  assign vs = int'(vcnt) >= V_ACTIVE + V_FP && int'(vcnt) < V_ACTIVE + V_FP + V_SYNC;
  assign active = int'(hcnt) < H_ACTIVE && int'(vcnt) < V_ACTIVE;
  assign vblank = int'(vcnt) >= V_ACTIVE;
  assign vblank_start = hcnt == '0 && int'(vcnt) == V_ACTIVE;
endmodule

// File: rtl/vga_tile_ctrl.sv
// vga_tile_ctrl: tile-mapped VGA controller with border colour and vblank status
module vga_tile_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP = V_BP_D,
  parameter int TILE_LOG2 = 5,
  parameter int COLS = 20,
  parameter int ROWS = 15,
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 0,
  parameter bit SYNC_NEG = 1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        border,
  input  logic [31:0]       vdata,
  output logic [ADDR_W-1:0] vaddr,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vblank,
  output logic              vblank_start
);
  localparam int HW = $clog2(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int VW = $clog2(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  logic [HW-1:0] hcnt, col;
  logic [VW-1:0] vcnt, row;
  logic hs, vs, act, vb, vbs, grid, unused_bits;
  logic [7:0] raw, dly, pix;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt), .hs(hs), .vs(vs),
    .active(act), .vblank(vb), .vblank_start(vbs)
  );
  assign col = hcnt >> TILE_LOG2;
  assign row = vcnt >> TILE_LOG2;
  assign grid = int'(col) < COLS && int'(row) < ROWS;
  assign vaddr = grid ? ADDR_W'(int'(row) * (COLS / 4) + int'(col >> 2)) : '0;
  assign raw = {col[1:0], act, grid, hs, vs, vb, vbs};
  generate
    if (RD_LAT == 0) begin : g_nodly
      assign dly = raw;
    end else begin : g_dly
      logic [7:0] pipe [RD_LAT];
      // side-band terms wait RD_LAT clocks for the matching vdata
      always_ff @(posedge clk or posedge reset)
        if (reset) for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        else begin
          pipe[0] <= raw;
          for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
      assign dly = pipe[RD_LAT-1];
    end
  endgenerate
  assign pix = dly[5] ? (dly[4] ? 8'(vdata >> {~dly[7:6], 3'b000}) : border) : '0;
  assign unused_bits = ^pix[7:6];
  // register colour, sync and vblank so every pin shares one latency
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
      vga_hs <= SYNC_NEG;
      vga_vs <= SYNC_NEG;
      vblank <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      vga_r <= {pix[R_HI:R_LO], 2'b00};
      vga_g <= {pix[G_HI:G_LO], 2'b00};
      vga_b <= {pix[B_HI:B_LO], 2'b00};
      vga_hs <= dly[3] ^ SYNC_NEG;
      vga_vs <= dly[2] ^ SYNC_NEG;
      vblank <= dly[1];
      vblank_start <= dly[0];
    end
endmodule

// File: tb/tb_vga_tile_ctrl.sv
// tb_vga_tile_ctrl: directed checks of timing, tile fetch, border, latency and reset
module tb_vga_tile_ctrl;
  logic clk = 0, reset = 1;
  int cyc, n_cmp, n_bad;
  logic [31:0] vdata0, vdata1, vdata2, vdata3;
  logic [6:0] vaddr0, vaddr1, vaddr2;
  logic [1:0] vaddr3;
  logic [3:0] r0, g0, b0, r1, g1, b1, r2, g2, b2, r3, g3, b3;
  logic hs0, vs0, vb0, vbs0, hs1, vs1, vb1, vbs1, hs2, vs2, vb2, vbs2, hs3, vs3, vb3, vbs3;

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic logic [7:0] pb(input int n);
    return 8'(n + 27);
  endfunction

  function automatic logic [31:0] mw(input int a);
    return a == 11 ? 32'h002A0000 : {pb(4*a), pb(4*a+1), pb(4*a+2), pb(4*a+3)};
  endfunction

  assign vdata0 = mw(int'(vaddr0));
  assign vdata1 = mw(int'(vaddr1));
  assign vdata3 = 32'h0;
  always @(posedge clk) vdata2 <= mw(int'(vaddr2));

  vga_tile_ctrl d0 (.clk(clk), .reset(reset), .border(8'h30), .vdata(vdata0), .vaddr(vaddr0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hs(hs0), .vga_vs(vs0), .vblank(vb0), .vblank_start(vbs0));
  vga_tile_ctrl #(.COLS(16), .ROWS(8)) d1 (.clk(clk), .reset(reset), .border(8'h30), .vdata(vdata1),
    .vaddr(vaddr1), .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(hs1), .vga_vs(vs1), .vblank(vb1),
    .vblank_start(vbs1));
  vga_tile_ctrl #(.RD_LAT(1)) d2 (.clk(clk), .reset(reset), .border(8'h30), .vdata(vdata2), .vaddr(vaddr2),
    .vga_r(r2), .vga_g(g2), .vga_b(b2), .vga_hs(hs2), .vga_vs(vs2), .vblank(vb2), .vblank_start(vbs2));
  vga_tile_ctrl #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(10), .V_FP(1), .V_SYNC(2),
    .V_BP(2), .TILE_LOG2(2), .COLS(4), .ROWS(2), .ADDR_W(2)) d3 (.clk(clk), .reset(reset),
    .border(8'h00), .vdata(vdata3), .vaddr(vaddr3), .vga_r(r3), .vga_g(g3), .vga_b(b3), .vga_hs(hs3),
    .vga_vs(vs3), .vblank(vb3), .vblank_start(vbs3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int hs_f1, hs_r1, hs_f2, hs2_f1, vs3_f1, vbs_n, vb_n, vbs_a, vbs_b;
    logic p_hs0, p_hs2, p_vs3;
    n_cmp = 0; n_bad = 0;
    hs_f1 = 0; hs_r1 = 0; hs_f2 = 0; hs2_f1 = 0; vs3_f1 = 0;
    vbs_n = 0; vb_n = 0; vbs_a = 0; vbs_b = 0;
    #12;
    check("rst_rgb", {r0, g0, b0}, 12'h000);
    check("rst_sync", {hs0, vs0, hs2, vs2}, 4'hF);
    check("rst_vb", {vb0, vbs0, vb3, vbs3}, 4'h0);
    #10 reset = 0;
    #1;
    check("rel_rgb", {r0, g0, b0, r2, g2, b2}, 24'h0);
    check("rel_sync", {hs0, vs0, hs2, vs2}, 4'hF);
    p_hs0 = hs0; p_hs2 = hs2; p_vs3 = vs3;
    for (int k = 1; k <= 1500; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check("first_px_lat0", {r0, g0, b0, r2, g2, b2}, 24'h48C_000);
      if (k == 2) check("first_px_lat1", {r2, g2, b2}, 12'h48C);
      if (p_hs0 && !hs0) begin
        if (hs_f1 == 0) hs_f1 = cyc;
        else if (hs_f2 == 0) hs_f2 = cyc;
      end
      if (!p_hs0 && hs0 && hs_r1 == 0) hs_r1 = cyc;
      if (p_hs2 && !hs2 && hs2_f1 == 0) hs2_f1 = cyc;
      if (p_vs3 && !vs3 && vs3_f1 == 0) vs3_f1 = cyc;
      if (vbs3) begin
        vbs_n++;
        if (vbs_a == 0) vbs_a = cyc;
        else if (vbs_b == 0) vbs_b = cyc;
      end
      if (vb3) vb_n++;
      p_hs0 = hs0; p_hs2 = hs2; p_vs3 = vs3;
    end
    check("hs_first_fall", hs_f1, 657);
    check("hs_low_width", hs_r1 - hs_f1, 96);
    check("hs_period", hs_f2 - hs_f1, 800);
    check("hs_fall_lat1", hs2_f1, 658);
    check("vs_fall_small", vs3_f1, 265);
    check("vbs_first", vbs_a, 241);
    check("vbs_period", vbs_b - vbs_a, 360);
    check("vbs_count", vbs_n, 4);
    check("vb_high_count", vb_n, 480);
    goto(8101);  check("grid_px", {r1, g1, b1}, 12'h4C8);
    goto(8521);  check("col_eq_cols", {r1, g1, b1}, 12'hC00);
    goto(8601);  check("border_px", {r1, g1, b1}, 12'hC00);
    goto(8640);  check("last_active", {r1, g1, b1}, 12'hC00);
    goto(8641);  check("first_blank", {r1, g1, b1}, 12'h000);
    goto(8701);  check("hblank_px", {r1, g1, b1}, 12'h000);
    goto(56165); check("vaddr_c5r2", {vaddr0, vaddr2}, {7'd11, 7'd11});
    goto(56166); check("px_2a_lat0", {r0, g0, b0}, 12'h888);
    goto(56167); check("px_2a_lat1", {r2, g2, b2}, 12'h888);
    goto(56300);
    check("pre_rst_px", {r0, g0, b0}, 12'h0C0);
    check("pre_rst_vaddr", vaddr0, 7'd12);
    #2 reset = 1;
    #1;
    check("mid_rst_rgb", {r0, g0, b0, r2, g2, b2}, 24'h0);
    check("mid_rst_sync", {hs0, vs0, vb0, vbs0}, 4'b1100);
    check("mid_rst_vaddr", vaddr0, 7'd0);
    @(negedge clk) reset = 0;
    goto(1);   check("restart_px", {r0, g0, b0}, 12'h48C);
    goto(656); check("restart_hs_hi", hs0, 1'b1);
    goto(657); check("restart_hs_lo", hs0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
